// File: rtl/hash_stream_if_pkg.sv
// Shared types and helpers for the hash_stream_if host interface and its word packer.
package hash_stream_if_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StHash  = 3'd2,
    StFinal = 3'd3,
    StFetch = 3'd4
  } state_e;

  // Widest host word the byte reversal helper handles.
  localparam int unsigned MaxWordBits = 1024;

  typedef logic [MaxWordBits-1:0] wide_word_t;

  // Counter width for n distinct values; never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverses the byte order of the w-bit word held in the low bits of x.
  function automatic wide_word_t byte_rev(input wide_word_t x, input int unsigned w);
    wide_word_t r;
    for (int b = 0; b < MaxWordBits / 8; b++) begin
      r[8*b +: 8] = x[MaxWordBits-8*(b+1) +: 8];
    end
    return r >> (MaxWordBits - w);
  endfunction

endpackage

// File: rtl/hash_word_packer.sv
// Word slot decoder plus optional byte reversal; used for block writes and the digest read mux.
module hash_word_packer
  import hash_stream_if_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned N        = 32,
  parameter bit          BYTE_REV = 1'b1,
  localparam int unsigned IW      = cnt_bits(N)
) (
  input  logic [W-1:0]  word,
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  word_out,
  output logic [N-1:0]  sel
);

  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      sel[k] = (idx == IW'(k));
    end
  end

  always_comb begin
    if (BYTE_REV) begin
      word_out = W'(byte_rev(wide_word_t'(word), W));
    end else begin
      word_out = word;
    end
  end

endmodule

// File: rtl/hash_stream_if.sv
// Word-serial host interface for iterative hash compression cores.
// Optional HASH_STREAM_IF_BLKCNT_EN adds a block counter injected into the final block.
module hash_stream_if
  import hash_stream_if_pkg::*;
#(
  parameter int unsigned           W           = 16,
  parameter int unsigned           BLOCK_BITS  = 512,
  parameter int unsigned           STATE_BITS  = 512,
  parameter int unsigned           DIGEST_BITS = 256,
  parameter int unsigned           DIGEST_OFS  = 256,
  parameter logic [STATE_BITS-1:0] IV          = '0,
  parameter bit                    BYTE_REV    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  load,
  input  logic                  fetch,
  input  logic [W-1:0]          idata,
  output logic                  ack,
  output logic [W-1:0]          odata,
  output logic                  busy,
  output logic                  core_ena,
  output logic                  core_final,
  output logic [BLOCK_BITS-1:0] core_block,
  output logic [STATE_BITS-1:0] core_stat_i,
  input  logic [STATE_BITS-1:0] core_stat_o,
  input  logic                  core_fin
`ifdef HASH_STREAM_IF_BLKCNT_EN
  ,
  output logic [31:0]           blk_cnt
`endif
);

  localparam int unsigned R   = BLOCK_BITS / W;
  localparam int unsigned D   = DIGEST_BITS / W;
  localparam int unsigned WCW = cnt_bits(R);
  localparam int unsigned DCW = cnt_bits(D);

  state_e                  state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic [DCW-1:0]          dcnt_q, dcnt_d;
  logic [BLOCK_BITS-1:0]   block_q;
  logic [STATE_BITS-1:0]   chain_q;
  logic                    finalised_q;
  logic                    ack_q, busy_q, ena_q, final_q;
  logic [W-1:0]            odata_q;

  logic                    load_we, fetch_rd, start_norm, start_final;
  logic                    chain_iv, chain_res, fin_set;
  logic                    wlast, dlast;
  logic [W-1:0]            wword, dword_raw, dword;
  logic [R-1:0]            wsel;
  logic [D-1:0]            dsel;
  logic [DIGEST_BITS-1:0]  digest;

  assign wlast  = (wcnt_q == WCW'(R - 1));
  assign dlast  = (dcnt_q == DCW'(D - 1));
  assign digest = chain_q[DIGEST_OFS +: DIGEST_BITS];

  hash_word_packer #(
    .W        (W),
    .N        (R),
    .BYTE_REV (BYTE_REV)
  ) u_load_packer (
    .word     (idata),
    .idx      (wcnt_q),
    .word_out (wword),
    .sel      (wsel)
  );

  // Word k=0 is the most significant word of the digest field.
  always_comb begin
    dword_raw = '0;
    for (int j = 0; j < D; j++) begin
      if (dsel[j]) dword_raw |= digest[W*(D-1-j) +: W];
    end
  end

  hash_word_packer #(
    .W        (W),
    .N        (D),
    .BYTE_REV (BYTE_REV)
  ) u_digest_packer (
    .word     (dword_raw),
    .idx      (dcnt_q),
    .word_out (dword),
    .sel      (dsel)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    dcnt_d      = dcnt_q;
    load_we     = 1'b0;
    fetch_rd    = 1'b0;
    start_norm  = 1'b0;
    start_final = 1'b0;
    chain_iv    = 1'b0;
    chain_res   = 1'b0;
    fin_set     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init) begin
          chain_iv = 1'b1;
          wcnt_d   = '0;
          dcnt_d   = '0;
        end else if (load && !finalised_q) begin
          load_we = 1'b1;
        end else if (fetch) begin
          if (finalised_q) begin
            state_d = StFetch;
          end else begin
            state_d     = StFinal;
            start_final = 1'b1;
          end
        end
      end
      StLoad: begin
        if (load) load_we = 1'b1;
      end
      StHash: begin
        if (core_fin) begin
          chain_res = 1'b1;
          state_d   = StIdle;
        end
      end
      StFinal: begin
        if (core_fin) begin
          chain_res = 1'b1;
          fin_set   = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        if (fetch) begin
          fetch_rd = 1'b1;
          if (dlast) begin
            dcnt_d  = '0;
            state_d = StIdle;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_we) begin
      if (wlast) begin
        wcnt_d     = '0;
        state_d    = StHash;
        start_norm = 1'b1;
      end else begin
        wcnt_d  = wcnt_q + 1'b1;
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
      block_q     <= '0;
      chain_q     <= IV;
      finalised_q <= 1'b0;
      ack_q       <= 1'b0;
      odata_q     <= '0;
      busy_q      <= 1'b0;
      ena_q       <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      ack_q   <= load_we | fetch_rd;
      ena_q   <= start_norm | start_final;
      final_q <= start_final;
      busy_q  <= (state_d == StLoad) || (state_d == StHash) || (state_d == StFinal);
      if (fetch_rd) odata_q <= dword;
      if (chain_iv) begin
        chain_q     <= IV;
        finalised_q <= 1'b0;
      end else begin
        if (chain_res) chain_q <= core_stat_o;
        if (fin_set) finalised_q <= 1'b1;
      end
      for (int j = 0; j < R; j++) begin
        if (load_we && wsel[j]) block_q[W*j +: W] <= wword;
      end
    end
  end

`ifdef HASH_STREAM_IF_BLKCNT_EN
  logic [31:0] blk_q;

  always_ff @(posedge clk) begin
    if (rst || chain_iv) begin
      blk_q <= '0;
    end else if (start_norm && (blk_q != 32'hFFFF_FFFF)) begin
      blk_q <= blk_q + 32'd1;
    end
  end

  assign blk_cnt = blk_q;

  // The final compression sees the block count in the top 32 bits of the block.
  always_comb begin
    core_block = block_q;
    if (state_q == StFinal) core_block[BLOCK_BITS-1 -: 32] = blk_q;
  end
`else
  always_comb begin
    core_block = block_q;
  end
`endif

  assign ack         = ack_q;
  assign odata       = odata_q;
  assign busy        = busy_q;
  assign core_ena    = ena_q;
  assign core_final  = final_q;
  assign core_stat_i = chain_q;

endmodule

// File: tb/tb_hash_stream_if.sv
// Directed bench for hash_stream_if with a stub core (fin 4 cycles after ena, result stat_i+1).
module tb_hash_stream_if;

  // Non-zero IV so that digest words are distinguishable.
  function automatic logic [511:0] mk_iv();
    logic [511:0] v;
    for (int j = 0; j < 32; j++) v[16*j +: 16] = {8'(j + 1), 8'(8'hA0 + j)};
    return v;
  endfunction

  localparam logic [511:0] TB_IV = mk_iv();

  logic         clk, rst, init, load, fetch;
  logic [15:0]  idata, odata;
  logic         ack, busy, core_ena, core_final, core_fin;
  logic [511:0] core_block, core_stat_i, core_stat_o;
`ifdef HASH_STREAM_IF_BLKCNT_EN
  logic [31:0]  blk_cnt;
`endif

  hash_stream_if #(
    .W           (16),
    .BLOCK_BITS  (512),
    .STATE_BITS  (512),
    .DIGEST_BITS (256),
    .DIGEST_OFS  (256),
    .IV          (TB_IV),
    .BYTE_REV    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .load        (load),
    .fetch       (fetch),
    .idata       (idata),
    .ack         (ack),
    .odata       (odata),
    .busy        (busy),
    .core_ena    (core_ena),
    .core_final  (core_final),
    .core_block  (core_block),
    .core_stat_i (core_stat_i),
    .core_stat_o (core_stat_o),
    .core_fin    (core_fin)
`ifdef HASH_STREAM_IF_BLKCNT_EN
    ,
    .blk_cnt     (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub compression core.
  logic [511:0] cap;
  int           cdown;
  always @(posedge clk) begin
    core_fin <= 1'b0;
    if (rst) begin
      cdown <= 0;
    end else if (core_ena) begin
      cap   <= core_stat_i;
      cdown <= 3;
    end else if (cdown > 0) begin
      cdown <= cdown - 1;
      if (cdown == 1) begin
        core_fin    <= 1'b1;
        core_stat_o <= cap + 512'd1;
      end
    end
  end

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MIdle = 0, MLoad = 1, MHash = 2, MFinal = 3, MFetch = 4;
  int           m_mode, m_w, m_k;
  logic [511:0] m_chain, m_stat;
  logic [15:0]  m_block [32];
  logic [31:0]  m_blk;
  logic         m_fin, m_ack, m_ena, m_final, m_busy, m_oval, started;
  logic [15:0]  m_odata;

  function automatic logic [15:0] swap(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  task automatic m_accept_load();
    m_block[m_w] = swap(idata);
    m_ack = 1'b1;
    if (m_w == 31) begin
      m_w = 0; m_mode = MHash; m_ena = 1'b1; m_stat = m_chain; m_blk++;
    end else begin
      m_w++; m_mode = MLoad;
    end
  endtask

  task automatic model_step();
    m_ack = 1'b0; m_ena = 1'b0; m_final = 1'b0; m_oval = 1'b0;
    if (rst) begin
      m_mode = MIdle; m_chain = TB_IV; m_fin = 1'b0; m_w = 0; m_k = 0; m_blk = '0;
      m_busy = 1'b0;
      for (int j = 0; j < 32; j++) m_block[j] = '0;
    end else begin
      case (m_mode)
        MIdle: begin
          if (init) begin
            m_chain = TB_IV; m_fin = 1'b0; m_w = 0; m_k = 0; m_blk = '0;
          end else if (load && !m_fin) begin
            m_accept_load();
          end else if (fetch) begin
            if (m_fin) m_mode = MFetch;
            else begin
              m_mode = MFinal; m_ena = 1'b1; m_final = 1'b1; m_stat = m_chain;
            end
          end
        end
        MLoad: if (load) m_accept_load();
        MHash: if (core_fin) begin m_chain = m_stat + 512'd1; m_mode = MIdle; end
        MFinal: if (core_fin) begin
          m_chain = m_stat + 512'd1; m_fin = 1'b1; m_mode = MFetch;
        end
        default: begin
          if (fetch) begin
            m_ack = 1'b1; m_oval = 1'b1;
            m_odata = swap(m_chain[511-16*m_k -: 16]);
            m_k++;
            if (m_k == 16) begin m_k = 0; m_mode = MIdle; end
          end else begin
            m_mode = MIdle;
          end
        end
      endcase
      m_busy = (m_mode == MLoad) || (m_mode == MHash) || (m_mode == MFinal);
    end
    started = 1'b1;
  endtask

  function automatic logic [511:0] exp_block();
    logic [511:0] v;
    for (int j = 0; j < 32; j++) v[16*j +: 16] = m_block[j];
`ifdef HASH_STREAM_IF_BLKCNT_EN
    if (m_final) v[511:480] = m_blk;
`endif
    return v;
  endfunction

  initial begin
    started = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int          ena_cnt = 0, final_cnt = 0;
  logic [31:0] final_top;
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("ack", 512'(ack), 512'(m_ack));
        chk("core_ena", 512'(core_ena), 512'(m_ena));
        chk("busy", 512'(busy), 512'(m_busy));
        if (m_ena) begin
          chk("core_final", 512'(core_final), 512'(m_final));
          chk("core_stat_i", core_stat_i, m_stat);
          chk("core_block", core_block, exp_block());
        end
        if (m_oval) chk("odata", 512'(odata), 512'(m_odata));
        if (core_ena === 1'b1) ena_cnt++;
        if (core_ena === 1'b1 && core_final === 1'b1) begin
          final_cnt++;
          final_top = core_block[511:480];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] got [32];
  int          got_n;

  task automatic do_load(input int n, input logic [15:0] first);
    for (int i = 0; i < n; i++) begin
      load = 1'b1; idata = first + 16'(i);
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      nchecks++; nerrors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, t);
    end
  endtask

  task automatic do_fetch(input int n);
    int t = 0;
    got_n = 0;
    fetch = 1'b1;
    while (got_n < n && t < 200) begin
      @(negedge clk); t++;
      if (ack === 1'b1) begin got[got_n] = odata; got_n++; end
    end
    fetch = 1'b0;
    if (got_n < n) begin
      nchecks++; nerrors++;
      $display("FAIL fetch_timeout: got %0d words, required %0d", got_n, n);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; init = 1'b0; load = 1'b0; fetch = 1'b0; idata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 512'(ack), 512'd0);
    chk("rst_odata", 512'(odata), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_ena", 512'(core_ena), 512'd0);
    chk("rst_block", core_block, 512'd0);
    chk("rst_chain", core_stat_i, TB_IV);
    rst = 1'b0;

    // 1: one block of 16'h0001..16'h0020
    init = 1'b1; @(negedge clk); init = 1'b0;
    do_load(32, 16'h0001);
    chk("t1_ena", 512'(core_ena), 512'd1);
    chk("t1_busy", 512'(busy), 512'd1);
    chk("t1_word0", 512'(core_block[15:0]), 512'h0100);
    chk("t1_word31", 512'(core_block[511:496]), 512'h2000);
    // 3: load during HASH is ignored, next block gives one more compression
    load = 1'b1; idata = 16'hFFFF;
    repeat (3) begin @(negedge clk); chk("t3_no_ack", 512'(ack), 512'd0); end
    load = 1'b0;
    wait_idle();
    chk("t3_chain", core_stat_i, TB_IV + 512'd1);
    do_load(32, 16'h0021);
    wait_idle();
    chk("t3_ena_cnt", 512'(ena_cnt), 512'd2);

    // 2: finalise and stream the digest
    do_fetch(16);
    chk("t2_final_cnt", 512'(final_cnt), 512'd1);
    chk("t2_word0", 512'(got[0]), 512'hBF20);
    chk("t2_word15", 512'(got[15]), 512'hB011);
    chk("t2_chain", core_stat_i, TB_IV + 512'd3);

    // 4: reset in the middle of a load run
    init = 1'b1; @(negedge clk); init = 1'b0;
    do_load(10, 16'h5000);
    rst = 1'b1; load = 1'b1; idata = 16'h5555;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    chk("t4_ack", 512'(ack), 512'd0);
    chk("t4_busy", 512'(busy), 512'd0);
    chk("t4_chain", core_stat_i, TB_IV);
    do_load(32, 16'h1234);
    chk("t4_word0", 512'(core_block[15:0]), 512'h3412);
    chk("t4_ena", 512'(core_ena), 512'd1);
    wait_idle();

    // 5: init beats load; digest read wraps after 16 words
    init = 1'b1; load = 1'b1; idata = 16'hAAAA;
    @(negedge clk);
    init = 1'b0; load = 1'b0;
    chk("t5_no_ack", 512'(ack), 512'd0);
    do_fetch(17);
    chk("t5_word0", 512'(got[0]), 512'hBF20);
    chk("t5_wrap", 512'(got[16]), 512'hBF20);

`ifdef HASH_STREAM_IF_BLKCNT_EN
    // 6: block count of three presented to the final compression
    init = 1'b1; @(negedge clk); init = 1'b0;
    for (int b = 0; b < 3; b++) begin
      do_load(32, 16'(16'h0100 * (b + 1)));
      wait_idle();
    end
    do_fetch(16);
    chk("t6_blk_cnt", 512'(blk_cnt), 512'd3);
    chk("t6_final_top", 512'(final_top), 512'd3);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
